fifo_unpacker: RTL and testbench
================================

# fifo_unpacker

Downstream drain stage for the 32-bit synchronous word FIFO. It issues FIFO reads, absorbs the FIFO's one-cycle registered read latency in a two-word buffer, and unpacks each 32-bit word into ELEM_W-bit elements. Elements leave on a valid/ready stream, lane 0 (LSBs) first, with a tile-boundary marker for the tensor datapath.

## Interface
- ELEM_W, 8: element width; legal values 8, 16, 32. LANES = 32/ELEM_W.
- TILE_LEN, 16: elements per tile; range 2..65536. out_last marks the final element of each tile.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered and in-flight data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  FIFO read strobe, combinational.
- fifo_rdata  in  32  FIFO read data; valid only in the cycle after fifo_read.
- out_valid  out  1  element available.
- out_ready  in  1  consumer accepts the element.
- out_data  out  ELEM_W  current element.
- out_last  out  1  current element is the last of its tile.
- busy  out  1  occ != 0 or pending == 1.

## Operation
- State:
  - occ: 0..2, buffered words.
  - pending: a read was issued last cycle.
  - lane: 0..LANES-1.
  - tile_idx: 0..TILE_LEN-1.
  - buffer: two 32-bit words, head/tail.
- Capture: when pending=1, fifo_rdata is written to the buffer tail. This is the only cycle rdata is sampled; idle rdata (e.g. 0xDEAD) is never used.
- pop = out_valid & out_ready & (lane == LANES-1).
- occ_next = occ + pending - pop.
- fifo_read = !rst & !flush & !fifo_empty & (occ_next < 2).
  - Never asserted while fifo_empty=1, because the FIFO advances its pointer even on an empty read.
- out_valid = (occ != 0). out_data = head[lane*ELEM_W +: ELEM_W].
- On an accepted element, lane increments. On the last lane, lane returns to 0 and the head pops; the tail becomes the head.
- tile_idx increments on every accepted element and wraps TILE_LEN-1 -> 0. out_last = out_valid & (tile_idx == TILE_LEN-1).
- Tiles span word boundaries freely; TILE_LEN need not be a multiple of LANES.
- Simultaneous capture and pop in the same cycle: occ stays the same, and the new word lands behind the surviving entry.
- flush (cycle t):
  - fifo_read=0.
  - occ, lane and tile_idx go to 0.
  - If pending=1, the fifo_rdata of cycle t is discarded.
  - pending=0 at t+1.
  - flush has no effect on the FIFO contents.
- rst has priority over flush.

## Timing
- Reset values: fifo_read=0, out_valid=0, out_last=0, busy=0, out_data=0. Internal state: occ=0, pending=0, lane=0, tile_idx=0, buffer=0.
- A reset asserted mid-operation drops all state in the same edge. A word arriving the cycle after reset is ignored, because pending was cleared.
- Latency: fifo_empty falls with occ=0 at cycle t -> fifo_read at t -> capture at the t+1 edge -> out_valid at t+2.
- Throughput: 1 element/cycle sustained with out_ready=1, for every ELEM_W, including 1 word/cycle at ELEM_W=32.
- Handshake: while out_valid=1 & out_ready=0, out_data, out_last and out_valid hold stable. out_valid never drops without acceptance, except on rst/flush.
- Backpressure: with out_ready=0, at most 2 words are read (occ=2), then fifo_read stays 0.

## Test plan
- Reset: hold rst 3 cycles with fifo_empty=0 -> fifo_read=0, out_valid=0, busy=0 throughout. First fifo_read in the cycle rst falls.
- ELEM_W=8, FIFO holds 0x44332211, 0x88776655, out_ready=1 -> out_data 0x11..0x88 on 8 consecutive cycles starting 2 cycles after the first read. Exactly 2 read strobes, none while empty.
- ELEM_W=8, TILE_LEN=16, out_ready low for 10 cycles mid-word -> data held stable, exactly 2 reads issued. After release, output continues with no loss or duplication. out_last on elements 16 and 32.
- ELEM_W=32, TILE_LEN=16, 40 words, out_ready=1 -> one word per cycle with no bubbles after a 2-cycle startup. out_last on words 16 and 32. tile_idx=8 at the end.
- Flush with pending=1 and occ=1, FIFO next holding 0xCAFEF00D -> neither buffered word is emitted. Next element is 0x0D (ELEM_W=8) with tile_idx=0.
- rst pulsed while pending=1 and out_ready=0 -> in-flight word dropped. Output resumes from the next FIFO word, lane 0, tile_idx=0.

Source files
------------

// File: rtl/fifo_unpacker.sv
// Drain stage for the 32-bit word FIFO: issues reads, buffers up to two words to cover the
// one-cycle read latency, and streams each word out as ELEM_W-bit elements, lane 0 first.
module fifo_unpacker #(
  parameter int ELEM_W   = 8,
  parameter int TILE_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [31:0]       fifo_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int LANES   = 32 / ELEM_W;
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LANE_N  = 2 ** LANE_W;
  localparam int TILE_W  = $clog2(TILE_LEN);

  logic [1:0]        occ_reg, occ_next;
  logic              pending_reg, pending_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [TILE_W-1:0] tile_reg, tile_next;
  logic [31:0]       head_reg, head_next;
  logic [31:0]       tail_reg, tail_next;

  logic              accept;
  logic              pop;
  logic              last_lane;
  logic              tile_last;
  logic [2:0]        occ_sum;
  logic [1:0]        wr_slot;
  logic [ELEM_W-1:0] lane_elem [LANE_N];

  // Lane selector is padded to a power of two so the index width always matches.
  for (genvar gi = 0; gi < LANE_N; gi++) begin : g_lane
    if (gi < LANES) begin : g_used
      assign lane_elem[gi] = head_reg[gi*ELEM_W +: ELEM_W];
    end else begin : g_pad
      assign lane_elem[gi] = '0;
    end
  end

  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = lane_elem[lane_reg];
  assign last_lane = (lane_reg == LANE_W'(LANES - 1));
  assign tile_last = (tile_reg == TILE_W'(TILE_LEN - 1));
  assign out_last  = out_valid & tile_last;
  assign busy      = out_valid | pending_reg;

  assign accept  = out_valid & out_ready;
  assign pop     = accept & last_lane;
  assign occ_sum = {1'b0, occ_reg} + {2'b00, pending_reg} - {2'b00, pop};
  // Read only if the word can still fit once the in-flight one lands.
  assign fifo_read = !rst && !flush && !fifo_empty && (occ_sum < 3'd2);
  // Arriving word goes behind whatever survives this cycle's pop.
  assign wr_slot = occ_reg - {1'b0, pop};

  always_comb begin
    occ_next     = occ_sum[1:0];
    pending_next = fifo_read;
    lane_next    = lane_reg;
    tile_next    = tile_reg;
    head_next    = head_reg;
    tail_next    = tail_reg;

    if (pop) begin
      head_next = tail_reg;
    end
    if (pending_reg) begin
      if (wr_slot == 2'd0) begin
        head_next = fifo_rdata;
      end else begin
        tail_next = fifo_rdata;
      end
    end
    if (accept) begin
      lane_next = last_lane ? '0 : lane_reg + LANE_W'(1);
      tile_next = tile_last ? '0 : tile_reg + TILE_W'(1);
    end

    if (flush) begin
      occ_next     = 2'd0;
      pending_next = 1'b0;
      lane_next    = '0;
      tile_next    = '0;
      head_next    = head_reg;
      tail_next    = tail_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg     <= 2'd0;
      pending_reg <= 1'b0;
      lane_reg    <= '0;
      tile_reg    <= '0;
      head_reg    <= 32'd0;
      tail_reg    <= 32'd0;
    end else begin
      occ_reg     <= occ_next;
      pending_reg <= pending_next;
      lane_reg    <= lane_next;
      tile_reg    <= tile_next;
      head_reg    <= head_next;
      tail_reg    <= tail_next;
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: an 8-bit and a 32-bit instance, each fed by a FIFO model and
// checked every cycle against an element-queue model, plus directed literal checks.
module tb_fifo_unpacker;

  localparam int TL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        rdy [2];
  logic        fe  [2];
  logic        fr  [2];
  logic        ov  [2];
  logic        ol  [2];
  logic        bz  [2];
  logic [31:0] frd [2];
  logic [31:0] od  [2];
  logic [31:0] mem [2][64];
  int          wp  [2];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int EW = (gi == 0) ? 8 : 32;
    localparam int LN = 32 / EW;

    logic [EW-1:0] d;
    int            rp       = 0;
    int            reads    = 0;
    int            tile_cnt = 0;
    int            acc_cnt  = 0;
    bit            pend     = 1'b0;
    logic [31:0]   pend_word = 32'd0;
    logic [EW-1:0] exp_q [$];

    fifo_unpacker #(.ELEM_W(EW), .TILE_LEN(TL)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fifo_empty (fe[gi]),
      .fifo_read  (fr[gi]),
      .fifo_rdata (frd[gi]),
      .out_valid  (ov[gi]),
      .out_ready  (rdy[gi]),
      .out_data   (d),
      .out_last   (ol[gi]),
      .busy       (bz[gi])
    );

    assign od[gi] = 32'(d);
    assign fe[gi] = (rp == wp[gi]);

    // FIFO with one-cycle registered read; idle data is junk
    always @(posedge clk) begin
      if (fr[gi] && rp < 64) begin
        frd[gi] <= mem[gi][rp];
        rp      <= rp + 1;
      end else begin
        frd[gi] <= 32'hDEAD;
      end
    end

    // Model: outstanding elements as a queue; words become elements the edge after the read
    always @(negedge clk) begin
      int sz, occ_m;
      bit acc, pop_m, exp_rd;
      sz     = exp_q.size();
      occ_m  = (sz + LN - 1) / LN;
      acc    = (ov[gi] === 1'b1) && rdy[gi];
      pop_m  = acc && ((sz - 1) % LN == 0);
      exp_rd = !rst && !flush && !fe[gi] && ((occ_m + int'(pend) - int'(pop_m)) < 2);
      chk($sformatf("i%0d_valid", gi), 32'(ov[gi]), 32'(sz != 0));
      chk($sformatf("i%0d_read", gi), 32'(fr[gi]), 32'(exp_rd));
      chk($sformatf("i%0d_busy", gi), 32'(bz[gi]), 32'(occ_m != 0 || pend));
      if (sz != 0) begin
        chk($sformatf("i%0d_data", gi), od[gi], 32'(exp_q[0]));
        chk($sformatf("i%0d_last", gi), 32'(ol[gi]), 32'(tile_cnt == TL - 1));
      end else begin
        chk($sformatf("i%0d_last_idle", gi), 32'(ol[gi]), 32'd0);
      end
      if (acc) $display("i%0d elem %0d data=%h last=%0d", gi, acc_cnt, od[gi], ol[gi]);
      if (rst || flush) begin
        exp_q.delete();
        tile_cnt = 0;
        pend     = 1'b0;
      end else begin
        if (acc && sz != 0) begin
          void'(exp_q.pop_front());
          tile_cnt = (tile_cnt + 1) % TL;
          acc_cnt++;
        end
        if (pend) begin
          for (int k = 0; k < LN; k++) exp_q.push_back(pend_word[k*EW +: EW]);
        end
        pend = fr[gi];
        if (fr[gi]) pend_word = mem[gi][rp];
      end
      if (fr[gi]) reads++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] cafe;
  int n, guard, r0, a0;

  initial begin
    cafe = 32'hCAFEF00D;
    rst = 1'b1; flush = 1'b0;
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    wp[1] = 0;
    mem[0][0] = 32'h44332211;
    mem[0][1] = 32'h88776655;
    wp[0] = 2;

    // reset held with a non-empty FIFO
    repeat (3) begin
      @(negedge clk);
      chk("rst_read", 32'(fr[0]), 32'd0);
      chk("rst_valid", 32'(ov[0]), 32'd0);
      chk("rst_busy", 32'(bz[0]), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0; rdy[0] = 1'b1;
    @(negedge clk);
    chk("first_read", 32'(fr[0]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("w8_valid", 32'(ov[0]), 32'd1);
      chk("w8_data", od[0], 32'(8'h11 * (k + 1)));
      @(negedge clk);
    end
    chk("w8_reads", 32'(g[0].reads), 32'd2);
    chk("w8_drained", 32'(ov[0]), 32'd0);

    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;

    // backpressure mid-word: element n carries value n
    for (int i = 0; i < 8; i++)
      mem[0][wp[0] + i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    wp[0] = wp[0] + 8;
    r0 = g[0].reads;
    n = 0; guard = 0;
    while (n < 32 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (ov[0] && rdy[0]) begin
        chk("bp_data", od[0], 32'(n));
        chk("bp_last", 32'(ol[0]), 32'(n == 15 || n == 31));
        n++;
        if (n == 2) begin
          @(posedge clk); #1 rdy[0] = 1'b0;
          for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(ov[0]), 32'd1);
            chk("bp_hold_data", od[0], 32'd2);
            chk("bp_hold_noread", 32'(fr[0]), 32'd0);
          end
          chk("bp_reads", 32'(g[0].reads - r0), 32'd2);
          @(posedge clk); #1 rdy[0] = 1'b1;
        end
      end
    end
    chk("bp_count", 32'(n), 32'd32);

    // 32-bit lanes: one word per cycle after two-cycle startup
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) mem[1][i] = 32'h1000 + i;
    wp[1] = 40; rdy[1] = 1'b1;
    @(negedge clk);
    chk("w32_read", 32'(fr[1]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      chk("w32_valid", 32'(ov[1]), 32'd1);
      chk("w32_data", od[1], 32'h1000 + k);
      chk("w32_last", 32'(ol[1]), 32'(k == 15 || k == 31));
      @(negedge clk);
    end
    chk("w32_drained", 32'(ov[1]), 32'd0);
    chk("w32_reads", 32'(g[1].reads), 32'd40);
    chk("w32_tile_model", 32'(g[1].tile_cnt), 32'd8);

    // advance the tile count to 12, then flush with pending=1 and occ=1
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) mem[0][wp[0] + i] = 32'hA3A2A1A0 + i;
    wp[0] = wp[0] + 3;
    a0 = g[0].acc_cnt; guard = 0;
    while (g[0].acc_cnt < a0 + 11 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("pre_count", 32'(g[0].acc_cnt - a0), 32'd11);
    @(posedge clk); #1;
    @(posedge clk); #1 rdy[0] = 1'b0;
    mem[0][wp[0]]     = 32'h11111111;
    mem[0][wp[0] + 1] = 32'h22222222;
    mem[0][wp[0] + 2] = 32'hCAFEF00D;
    wp[0] = wp[0] + 3;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("fl_valid", 32'(ov[0]), 32'd1);
    chk("fl_busy", 32'(bz[0]), 32'd1);
    chk("fl_noread", 32'(fr[0]), 32'd0);
    @(posedge clk); #1 flush = 1'b0; rdy[0] = 1'b1;
    n = 0; guard = 0;
    while (n < 4 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (ov[0] && rdy[0]) begin
        chk("fl_data", od[0], 32'(cafe[8*n +: 8]));
        chk("fl_last", 32'(ol[0]), 32'd0);
        n++;
      end
    end
    chk("fl_count", 32'(n), 32'd4);

    // reset while a read is in flight and the consumer stalls
    @(posedge clk); #1 rdy[0] = 1'b0;
    mem[0][wp[0]]     = 32'hAAAAAA01;
    mem[0][wp[0] + 1] = 32'h55555502;
    wp[0] = wp[0] + 2;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rs_noread", 32'(fr[0]), 32'd0);
    chk("rs_busy", 32'(bz[0]), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rs_valid", 32'(ov[0]), 32'd0);
    chk("rs_idle", 32'(bz[0]), 32'd0);
    chk("rs_read", 32'(fr[0]), 32'd1);
    @(posedge clk); #1 rdy[0] = 1'b1;
    n = 0; guard = 0;
    while (n < 1 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (ov[0] && rdy[0]) begin
        chk("rs_data", od[0], 32'h02);
        chk("rs_last", 32'(ol[0]), 32'd0);
        n++;
      end
    end
    chk("rs_count", 32'(n), 32'd1);
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
